// File: rtl/time_set_ctrl.sv
// Keypad HH:MM entry sequencer: range-checks digits into shadow BCD registers and commits on ENTER.
// Every key is handled the cycle it arrives (outputs one cycle later); key_valid is never stalled, only acked.
module time_set_ctrl #(
   parameter logic [15:0] TIMEOUT_CYC = 16'd1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       set_req,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   output logic       key_ack,
   output logic [7:0] hr_bcd,
   output logic [7:0] min_bcd,
   output logic       ld_time,
   output logic [1:0] edit_pos,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       abort
);

   localparam logic [3:0] KEY_ENTER  = 4'hA;
   localparam logic [3:0] KEY_CANCEL = 4'hB;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      HT      = 3'd1,
      HU      = 3'd2,
      MT      = 3'd3,
      MU      = 3'd4,
      CONFIRM = 3'd5
   } state_t;

   state_t      state;
   state_t      nxt_state;
   logic [15:0] tcnt;
   logic [15:0] nxt_tcnt;
   logic [7:0]  nxt_hr;
   logic [7:0]  nxt_min;
   logic        ack_d;
   logic        err_d;
   logic        abort_d;
   logic        ld_d;
   logic        is_digit;
   logic        digit_ok;

   function automatic logic [1:0] pos_of(input state_t s);
      case (s)
         HU:          pos_of = 2'd1;
         MT:          pos_of = 2'd2;
         MU, CONFIRM: pos_of = 2'd3;
         default:     pos_of = 2'd0;
      endcase
   endfunction

   assign is_digit = (key_code <= 4'd9);

   // Upper bound of the digit allowed in the current position (24-hour clock)
   always_comb begin
      case (state)
         HT:      digit_ok = (key_code <= 4'd2);
         HU:      digit_ok = (hr_bcd[7:4] == 4'd2) ? (key_code <= 4'd3) : is_digit;
         MT:      digit_ok = (key_code <= 4'd5);
         MU:      digit_ok = is_digit;
         default: digit_ok = 1'b0;
      endcase
   end

   always_comb begin
      nxt_state = state;
      nxt_hr    = hr_bcd;
      nxt_min   = min_bcd;
      nxt_tcnt  = tcnt;
      ack_d     = 1'b0;
      err_d     = 1'b0;
      abort_d   = 1'b0;
      ld_d      = 1'b0;
      if (state == IDLE) begin
         nxt_tcnt = 16'd0;
         if (set_req) begin
            nxt_state = HT;
            nxt_hr    = 8'h00;
            nxt_min   = 8'h00;
         end
      end else if (key_valid) begin
         ack_d    = 1'b1;
         nxt_tcnt = 16'd0;
         if (key_code == KEY_CANCEL) begin
            nxt_state = IDLE;
            abort_d   = 1'b1;
         end else if (key_code == KEY_ENTER) begin
            if (state == CONFIRM) begin
               nxt_state = IDLE;
               ld_d      = 1'b1;
            end else begin
               err_d = 1'b1;
            end
         end else if (is_digit) begin
            if (digit_ok) begin
               case (state)
                  HT: begin
                     nxt_hr[7:4] = key_code;
                     nxt_state   = HU;
                  end
                  HU: begin
                     nxt_hr[3:0] = key_code;
                     nxt_state   = MT;
                  end
                  MT: begin
                     nxt_min[7:4] = key_code;
                     nxt_state    = MU;
                  end
                  MU: begin
                     nxt_min[3:0] = key_code;
                     nxt_state    = CONFIRM;
                  end
                  default: nxt_state = state;
               endcase
            end else begin
               err_d = 1'b1;
            end
         end
      end else if (tcnt == TIMEOUT_CYC - 16'd1) begin
         // A key in this same cycle takes the branch above and wins over the timeout
         nxt_state = IDLE;
         nxt_tcnt  = 16'd0;
         abort_d   = 1'b1;
      end else begin
         nxt_tcnt = tcnt + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         tcnt     <= 16'd0;
         hr_bcd   <= 8'h00;
         min_bcd  <= 8'h00;
         key_ack  <= 1'b0;
         ld_time  <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         abort    <= 1'b0;
         busy     <= 1'b0;
         edit_pos <= 2'd0;
      end else begin
         state    <= nxt_state;
         tcnt     <= nxt_tcnt;
         hr_bcd   <= nxt_hr;
         min_bcd  <= nxt_min;
         key_ack  <= ack_d;
         ld_time  <= ld_d;
         done     <= ld_d;
         err      <= err_d;
         abort    <= abort_d;
         busy     <= (nxt_state != IDLE);
         edit_pos <= pos_of(nxt_state);
      end
   end

endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

Keypad-driven sequencer that walks the user through entering a new HH:MM time and commits it to the clock's time registers. It sits between the key scanner and the hours/minutes register datapath. It validates every digit against 24-hour ranges, holds the digits in shadow registers, and issues a single commit strobe on confirm. Cancel and an inactivity timeout abandon the entry without touching the live time.

## Interface

Parameters:
- TIMEOUT_CYC, 16'd1000: number of idle cycles without an accepted key, while editing, before the entry is aborted. Legal range 2..65535.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- set_req  input  1  one-cycle pulse that starts an entry session.
- key_valid  input  1  one-cycle pulse; key_code is valid in this cycle.
- key_code  input  4  key value: 0–9 = digit, 4'hA = ENTER, 4'hB = CANCEL, 4'hC–4'hF = ignored.
- key_ack  output  1  one-cycle pulse in the cycle after a key is consumed (acts as the key-clear to the scanner).
- hr_bcd  output  8  shadow hours as BCD, tens in bits [7:4].
- min_bcd  output  8  shadow minutes as BCD, tens in bits [7:4].
- ld_time  output  1  one-cycle load strobe to the time registers.
- edit_pos  output  2  digit under edit (0 = hour tens … 3 = minute units), used by the display blink.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse, coincident with ld_time.
- err  output  1  one-cycle pulse on a rejected key.
- abort  output  1  one-cycle pulse on a cancel or a timeout.

## Operation

- States: IDLE, HT, HU, MT, MU, CONFIRM. The state is 3 bits and all outputs are registered.
- IDLE:
  - set_req moves to HT and clears hr_bcd and min_bcd to 8'h00.
  - key_valid is ignored: no key_ack, no err.
  - If set_req and key_valid arrive in the same cycle, set_req is honoured and the key is dropped.
- Digit acceptance rules:
  - HT: digit ≤ 2.
  - HU: digit ≤ 9 if the hour tens is < 2; digit ≤ 3 if the hour tens is 2.
  - MT: digit ≤ 5.
  - MU: digit ≤ 9.
- Accepted digit: written into its shadow nibble and the state advances (HT→HU→MT→MU→CONFIRM). edit_pos follows the state: 0, 1, 2, 3, then 3 in CONFIRM.
- Rejected digit: err pulse, the state and shadow are unchanged, and key_ack is still issued.
- ENTER:
  - In CONFIRM it produces ld_time and done, then the block returns to IDLE.
  - In HT–MU it is rejected with err.
- Digit in CONFIRM: rejected with err.
- CANCEL in any non-IDLE state produces an abort pulse and a return to IDLE. ld_time is not issued. The shadow keeps its partial value, which is harmless because ld_time is not issued.
- Codes 4'hC–4'hF: key_ack only, no other effect.
- set_req while busy is ignored.
- Timeout counter (16 bits):
  - Cleared on entering HT and on every consumed key.
  - Increments each non-IDLE cycle without key_valid.
  - When it equals TIMEOUT_CYC-1 with no key_valid in that cycle, the next edge goes to IDLE with an abort pulse.
  - A key arriving in the terminal-count cycle wins: it is processed normally and the counter clears.
- rst at any time, including mid-entry: state IDLE, no strobes, the shadow is cleared.

## Timing

- Reset values: every output is 0, including hr_bcd = 8'h00, min_bcd = 8'h00 and edit_pos = 2'd0. The timeout counter is 0.
- set_req at edge N: busy = 1 and edit_pos = 0 from cycle N+1.
- key_valid at edge N:
  - The state and shadow update at edge N.
  - key_ack, err and abort are high for exactly cycle N+1.
- ENTER in CONFIRM at edge N:
  - ld_time and done are high in cycle N+1.
  - hr_bcd and min_bcd are stable through N+1 and held afterwards.
  - busy = 0 in cycle N+1.
- Back-to-back key_valid on consecutive cycles is legal; each key is processed independently.
- Full entry latency: 5 accepted keys, so the minimum is 6 cycles from set_req to ld_time.

## Test plan

- Normal entry: set_req, then keys 1, 9, 4, 5, ENTER → ld_time and done high for one cycle with hr_bcd = 8'h19 and min_bcd = 8'h45; busy falls in the same cycle; 5 key_ack pulses total.
- Range checks: set_req, then 3 → err with state HT. Continue with 2, 4 → err. Then 3, 6 → err. Then 5, 9, ENTER → hr_bcd = 8'h23, min_bcd = 8'h59, ld_time pulse.
- Cancel: set_req, then 1, 2, CANCEL → abort pulse, busy = 0, no ld_time. A following ENTER in IDLE produces no key_ack.
- Timeout with TIMEOUT_CYC = 4: after set_req, 4 idle cycles → abort and return to IDLE. In a second run, a key arriving in the terminal-count cycle is accepted and there is no abort.
- Early and late ENTER: ENTER in MT → err and the state stays MT. A digit in CONFIRM → err. A subsequent ENTER then commits.
- Reset mid-entry: rst asserted in MU → every output is 0 on the next cycle, including hr_bcd = 8'h00. A simultaneous set_req and key_valid in IDLE → HT entered and the key is dropped.
